// File: rtl/fifo_uart_tx.sv
// Drains bytes from a normal (non-show-ahead) FIFO and sends each one as a UART frame, 8N1 by default.
// Define UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       empty,
    input  logic [7:0] q,
    output logic       rdreq,
    output logic       txd,
    output logic       busy,
    output logic       tx_done
);

    localparam int          BAUD_DIV = CLK_FREQ / BAUD;
    localparam logic [15:0] DIV_LAST = 16'(BAUD_DIV - 1);
    localparam logic [15:0] DIV_PRE  = 16'(BAUD_DIV - 2);
    localparam bit          ONE_CLK_BIT = (BAUD_DIV == 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, RD, WAIT, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, RD, WAIT, START, DATA, STOP} state_t;
`endif

    state_t      state;
    logic [7:0]  shreg;
    logic [2:0]  bit_cnt;
    logic [15:0] baud_cnt;
`ifdef UART_PARITY_EN
    logic        parity_bit;
`endif

    // Every output is a register; txd is loaded with the level of the bit about to start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            txd      <= 1'b1;
            rdreq    <= 1'b0;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
            shreg    <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
`ifdef UART_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            rdreq   <= 1'b0;
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (!empty) begin
                        state    <= RD;
                        rdreq    <= 1'b1;
                        busy     <= 1'b1;
                        baud_cnt <= '0;
                    end
                end
                RD: begin
                    state    <= WAIT;
                    baud_cnt <= '0;
                end
                WAIT: begin
                    // q is valid now, one clk after the read request was seen by the FIFO
                    shreg    <= q;
`ifdef UART_PARITY_EN
                    parity_bit <= ^q;
`endif
                    state    <= START;
                    txd      <= 1'b0;
                    baud_cnt <= '0;
                end
                START: begin
                    if (baud_cnt == DIV_LAST) begin
                        state    <= DATA;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        txd      <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_cnt == DIV_LAST) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
`ifdef UART_PARITY_EN
                            state   <= PARITY;
                            txd     <= parity_bit;
`else
                            state   <= STOP;
                            txd     <= 1'b1;
                            tx_done <= ONE_CLK_BIT;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            txd     <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (baud_cnt == DIV_LAST) begin
                        state    <= STOP;
                        baud_cnt <= '0;
                        txd      <= 1'b1;
                        tx_done  <= ONE_CLK_BIT;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
`endif
                STOP: begin
                    txd <= 1'b1;
                    // tx_done is registered, so it is armed one cycle ahead of the final stop cycle
                    if (!ONE_CLK_BIT && baud_cnt == DIV_PRE) begin
                        tx_done <= 1'b1;
                    end
                    if (baud_cnt == DIV_LAST) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        baud_cnt <= '0;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    txd      <= 1'b1;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model feeding the DUT, per-cycle frame checks against a bit-list model.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int DIV      = CLK_FREQ / BAUD;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int START_TIMEOUT = 40 * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       empty = 1'b1;
  logic [7:0] q = 8'h00;
  logic       rdreq, txd, busy, tx_done;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int rd_bad = 0;
  logic rd_prev = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;
  vec_t tbl[9];

  fifo_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk), .reset(reset), .empty(empty), .q(q),
    .rdreq(rdreq), .txd(txd), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  // Normal FIFO: data appears one clk after a sampled read request
  always @(posedge clk) begin
    if (rdreq && fifo_q.size() > 0) q <= fifo_q.pop_front();
  end

  always @(negedge clk) begin
    empty = (fifo_q.size() == 0);
    if (reset) begin
      rd_prev = 1'b0;
    end else begin
      if (rdreq) rd_cnt++;
      if (rdreq && (rd_prev || !busy)) rd_bad++;
      rd_prev = rdreq;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic even_par(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return 1'(ones % 2);
  endfunction

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  // Waits for the next start bit, then checks every cycle of the frame; high = idle-high cycles seen before it
  task automatic expect_frame(input logic par, output int high);
    logic [7:0] b;
    logic exp_bits[NBITS];
    int waited, bad_bit, bad_done, bad_busy;
    high = 0;
    waited = 0;
    check("scoreboard_has_byte", int'(exp_q.size() > 0), 1);
    if (exp_q.size() == 0) return;
    b = exp_q.pop_front();
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[1 + i] = b[i];
`ifdef UART_PARITY_EN
    exp_bits[9] = par;
`endif
    exp_bits[NBITS - 1] = 1'b1;
    do begin
      @(negedge clk);
      waited++;
      if (txd) high++;
    end while (txd && waited < START_TIMEOUT);
    check($sformatf("start_bit_seen_%02h", b), int'(txd), 0);
    if (txd) return;
    bad_done = 0;
    bad_busy = 0;
    for (int k = 0; k < NBITS; k++) begin
      bad_bit = 0;
      for (int c = 0; c < DIV; c++) begin
        if (k > 0 || c > 0) @(negedge clk);
        if (txd !== exp_bits[k]) bad_bit++;
        if (tx_done !== ((k == NBITS - 1) && (c == DIV - 1))) bad_done++;
        if (busy !== 1'b1) bad_busy++;
      end
      check($sformatf("byte_%02h_bit%0d_bad_cycles", b, k), bad_bit, 0);
    end
    check($sformatf("byte_%02h_tx_done_bad_cycles", b), bad_done, 0);
    check($sformatf("byte_%02h_busy_low_cycles", b), bad_busy, 0);
  endtask

  initial begin
    int high, base, bad;
    logic [7:0] b;

    tbl[0] = '{8'h31, 1'b1};
    tbl[1] = '{8'h0d, 1'b1};
    tbl[2] = '{8'h0a, 1'b0};
    tbl[3] = '{8'h07, 1'b1};
    tbl[4] = '{8'h03, 1'b0};
    tbl[5] = '{8'h00, 1'b0};
    tbl[6] = '{8'hff, 1'b0};
    tbl[7] = '{8'h80, 1'b1};
    tbl[8] = '{8'ha5, 1'b0};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_txd", int'(txd), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_rdreq", int'(rdreq), 0);
    check("reset_tx_done", int'(tx_done), 0);
    reset = 1'b0;

    // Empty FIFO: nothing may move
    bad = 0;
    repeat (2000) begin
      @(negedge clk);
      if (rdreq || !txd || busy || tx_done) bad++;
    end
    check("idle_activity_cycles", bad, 0);

    // Single byte from idle
    base = rd_cnt;
    @(posedge clk); #1;
    push_byte(8'ha5);
    @(negedge clk);
    expect_frame(1'b0, high);
    check("first_start_latency", high + 1, 3);
    @(negedge clk);
    check("busy_after_frame", int'(busy), 0);
    check("txd_after_frame", int'(txd), 1);
    check("single_rdreq_pulses", rd_cnt - base, 1);

    // Table burst, back-to-back frames with 3-clk gaps
    base = rd_cnt;
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) push_byte(tbl[i].data);
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      expect_frame(tbl[i].par, high);
      check($sformatf("gap_before_frame_%0d", i), (i == 0) ? high + 1 : high, 3);
    end
    check("burst_rdreq_pulses", rd_cnt - base, 9);

    // Random bytes with random idle time between them
    for (int n = 0; n < 20; n++) begin
      b = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      push_byte(b);
      @(negedge clk);
      expect_frame(even_par(b), high);
      check($sformatf("rand_latency_%0d", n), high + 1, 3);
      repeat ($urandom_range(0, 15)) @(negedge clk);
    end

    // Reset in the middle of data bit 4 aborts the frame
    @(posedge clk); #1;
    push_byte(8'h0f);
    @(negedge clk);
    bad = 0;
    while (txd && bad < START_TIMEOUT) begin
      @(negedge clk);
      bad++;
    end
    check("abort_frame_started", int'(txd), 0);
    repeat (5 * DIV + DIV / 2) @(negedge clk);
    check("bit4_before_reset", int'(txd), 0);
    reset = 1'b1;
    #1;
    check("abort_txd", int'(txd), 1);
    check("abort_busy", int'(busy), 0);
    void'(exp_q.pop_front());
    repeat (4) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (rdreq || !txd || busy) bad++;
    end
    check("post_reset_activity_cycles", bad, 0);

    reset = 1'b1;
    push_byte(8'hc3);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    expect_frame(1'b0, high);
    check("restart_latency", high + 1, 3);

    repeat (5) @(negedge clk);
    check("rdreq_protocol_violations", rd_bad, 0);
    check("fifo_leftover", fifo_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
